// File: rtl/encoder_prio_seq.sv
// Sequential priority encoder: sticky pending register, one binary code per valid/ready transfer.
// Optional macro ENCODER_RR_PRIORITY_EN selects round-robin instead of fixed highest-index priority.
module encoder_prio_seq #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         E,
   input  logic [N-1:0] A,
   input  logic         CLR,
   input  logic         R,
   output logic [W-1:0] S,
   output logic         V,
   output logic [N-1:0] P,
   output logic         OVF
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t       state_q;
   logic [W-1:0] s_q;
   logic [N-1:0] p_q;
   logic         ovf_q;

   logic         accept_s;
   logic [N-1:0] accept_mask_s;
   logic [N-1:0] cap_s;
   logic [N-1:0] p_d;
   logic         ovf_hit_s;
   logic [W-1:0] win_idle_s;
   logic [W-1:0] win_next_s;

`ifdef ENCODER_RR_PRIORITY_EN
   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Scan downward from last-1 with wrap; the smallest distance from last wins.
   function automatic logic [W-1:0] pick(input logic [N-1:0] vec, input logic [W-1:0] last);
      logic [W-1:0] idx;
      logic [W-1:0] res;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         idx = last - W'(k);
         if (vec[idx]) begin
            res = idx;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`else
   function automatic logic [W-1:0] pick(input logic [N-1:0] vec);
      logic [W-1:0] res;
      res = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            res = W'(i);
         end else begin
            res = res;
         end
      end
      return res;
   endfunction
`endif

   // Transfer detection, capture merge, overflow detection and winner selection.
   always_comb begin
      accept_s      = (state_q == ST_HOLD) && R;
      accept_mask_s = accept_s ? ({{(N-1){1'b0}}, 1'b1} << s_q) : '0;
      cap_s         = E ? A : '0;
      p_d           = (p_q & ~accept_mask_s) | cap_s;
      ovf_hit_s     = |(cap_s & p_q & ~accept_mask_s);
`ifdef ENCODER_RR_PRIORITY_EN
      // A transfer moves the pointer at this edge, so the follow-on winner already sees it.
      ptr_d         = accept_s ? s_q : ptr_q;
      win_idle_s    = pick(p_q, ptr_d);
      win_next_s    = pick(p_d, ptr_d);
`else
      win_idle_s    = pick(p_q);
      win_next_s    = pick(p_d);
`endif
   end

   // Handshake FSM together with pending, code, overflow and pointer registers.
   always_ff @(posedge clk) begin
      if (!rst_n || CLR) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         p_q     <= '0;
         ovf_q   <= 1'b0;
`ifdef ENCODER_RR_PRIORITY_EN
         ptr_q   <= W'(N - 1);
`endif
      end else begin
         p_q   <= p_d;
         ovf_q <= ovf_q | ovf_hit_s;
`ifdef ENCODER_RR_PRIORITY_EN
         ptr_q <= ptr_d;
`endif
         case (state_q)
            ST_IDLE: begin
               if (|p_q) begin
                  state_q <= ST_HOLD;
                  s_q     <= win_idle_s;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (R && (|p_d)) begin
                  s_q     <= win_next_s;
               end else if (R) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign S   = s_q;
   assign V   = (state_q == ST_HOLD);
   assign P   = p_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_encoder_prio_seq.sv
// Bench for encoder_prio_seq: directed scenarios then random traffic, all cycles checked
// against an index-level reference model of the pending set and handshake.
module tb_encoder_prio_seq;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk;
   logic         rst_n;
   logic         E;
   logic [N-1:0] A;
   logic         CLR;
   logic         R;
   logic [W-1:0] S;
   logic         V;
   logic [N-1:0] P;
   logic         OVF;

   int cmp_cnt = 0;
   int err_cnt = 0;

   bit m_pend [N];
   bit m_valid;
   int m_code;
   bit m_ovf;
   int m_last;

   encoder_prio_seq #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .E(E), .A(A), .CLR(CLR), .R(R),
      .S(S), .V(V), .P(P), .OVF(OVF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit any_set(input bit v [N]);
      for (int i = 0; i < N; i++) if (v[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int winner(input bit v [N], input int last);
`ifdef ENCODER_RR_PRIORITY_EN
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last - k + 2 * N) % N;
         if (v[idx]) return idx;
      end
`else
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
`endif
      return 0;
   endfunction

   function automatic logic [N-1:0] pend_vec();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_pend[i];
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_code  = 0;
      m_ovf   = 1'b0;
      m_last  = N - 1;
   endtask

   task automatic model_edge();
      bit newp [N];
      int acc_idx;
      if (!rst_n || CLR) begin
         model_clear();
      end else begin
         acc_idx = (m_valid && R) ? m_code : -1;
         for (int i = 0; i < N; i++) begin
            bit keep;
            bit capd;
            keep = m_pend[i] && (i != acc_idx);
            capd = E && A[i];
            if (keep && capd) m_ovf = 1'b1;
            newp[i] = keep || capd;
         end
         if (acc_idx >= 0) m_last = acc_idx;
         if (!m_valid) begin
            if (any_set(m_pend)) begin
               m_valid = 1'b1;
               m_code  = winner(m_pend, m_last);
            end
         end else if (R) begin
            if (any_set(newp)) m_code = winner(newp, m_last);
            else m_valid = 1'b0;
         end
         m_pend = newp;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("P", 32'(P), 32'(pend_vec()));
      check("V", 32'(V), 32'(m_valid));
      check("S", 32'(S), 32'(m_code));
      check("OVF", 32'(OVF), 32'(m_ovf));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      model_clear();
      rst_n = 1'b0; E = 1'b1; A = 8'hFF; R = 1'b1; CLR = 1'b0;
      ticks(2);
      check("rst_P", 32'(P), 32'h0);
      check("rst_V", 32'(V), 32'h0);
      check("rst_S", 32'(S), 32'h0);
      check("rst_OVF", 32'(OVF), 32'h0);
      rst_n = 1'b1; A = 8'h00;
      ticks(2);
      check("idle_V", 32'(V), 32'h0);

      // single request
      A = 8'h20; tick();
      check("single_P1", 32'(P), 32'h20);
      A = 8'h00; tick();
      check("single_V2", 32'(V), 32'h1);
      check("single_S2", 32'(S), 32'h5);
      tick();
      check("single_V3", 32'(V), 32'h0);
      check("single_P3", 32'(P), 32'h0);

      // priority drain
      A = 8'h85; tick();
      A = 8'h00; tick();
`ifndef ENCODER_RR_PRIORITY_EN
      check("drain_S7", 32'(S), 32'h7);
`endif
      tick();
`ifndef ENCODER_RR_PRIORITY_EN
      check("drain_S2", 32'(S), 32'h2);
`endif
      tick();
`ifndef ENCODER_RR_PRIORITY_EN
      check("drain_S0", 32'(S), 32'h0);
`endif
      tick();
      check("drain_V0", 32'(V), 32'h0);
      A = 8'h81; tick(); A = 8'h00; ticks(4);
      A = 8'h81; tick(); A = 8'h00; ticks(4);

      // backpressure without preemption
      R = 1'b0; A = 8'h09; tick();
      A = 8'h00; ticks(5);
      check("bp_V", 32'(V), 32'h1);
      check("bp_S3", 32'(S), 32'h3);
      A = 8'h80; tick();
      check("bp_hold_S", 32'(S), 32'h3);
      check("bp_P89", 32'(P), 32'h89);
      A = 8'h00; tick();
      R = 1'b1; tick();
      check("bp_S7", 32'(S), 32'h7);
      tick();
      check("bp_S0", 32'(S), 32'h0);
      tick();
      check("bp_V0", 32'(V), 32'h0);

      // enable, overflow, clear
      E = 1'b0; A = 8'hFF; ticks(2);
      check("en_P", 32'(P), 32'h0);
      check("en_V", 32'(V), 32'h0);
      E = 1'b1; R = 1'b0; A = 8'h04; tick();
      A = 8'h00; tick();
      A = 8'h04; tick();
      check("ovf_set", 32'(OVF), 32'h1);
      A = 8'h00; R = 1'b1; ticks(3);
      check("ovf_sticky", 32'(OVF), 32'h1);
      CLR = 1'b1; A = 8'hFF; tick();
      check("clr_OVF", 32'(OVF), 32'h0);
      check("clr_P", 32'(P), 32'h0);
      check("clr_V", 32'(V), 32'h0);
      CLR = 1'b0; A = 8'h00; tick();

      // reset mid-operation
      R = 1'b0; A = 8'hF0; tick();
      A = 8'h00; tick();
      check("mid_V", 32'(V), 32'h1);
`ifndef ENCODER_RR_PRIORITY_EN
      check("mid_S7", 32'(S), 32'h7);
`endif
      rst_n = 1'b0; tick();
      check("mid_rst_P", 32'(P), 32'h0);
      check("mid_rst_S", 32'(S), 32'h0);
      rst_n = 1'b1; ticks(2);
      check("mid_stale_V", 32'(V), 32'h0);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(63) != 0);
         CLR   = ($urandom_range(31) == 0);
         E     = ($urandom_range(3) != 0);
         A     = N'($urandom & $urandom & $urandom);
         R     = $urandom_range(1);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
